ysyx_decode_alu: RTL and testbench

YSYX_DECODE_ALU -- requirements
Module: ysyx_decode_alu

---
 rtl/ysyx_decode_alu.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_decode_alu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_decode_alu.sv
// ysyx_decode_alu: single-stage RV64I decode and ALU.
// Every output comes from a register that captures the decode and execute
// result of the current inputs on each rising clock edge (1-cycle latency).
module ysyx_decode_alu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            valid_out,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      itype,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic [XLEN-1:0] next_pc
);

  typedef enum logic [3:0] {
    ITYPE_R      = 4'b0000,
    ITYPE_I      = 4'b0001,
    ITYPE_AUIPC  = 4'b0010,
    ITYPE_BRANCH = 4'b0011,
    ITYPE_STORE  = 4'b0100,
    ITYPE_LUI    = 4'b0101,
    ITYPE_LOAD   = 4'b1001,
    ITYPE_JALR   = 4'b1010,
    ITYPE_JAL    = 4'b1011,
    ITYPE_SYS    = 4'b1110,
    ITYPE_ILL    = 4'b1111
  } itype_e;

  itype_e          itype_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            isWord;
  logic            doSub;
  logic [XLEN-1:0] aluRes;
  logic [31:0]     wordRes;
  logic [XLEN-1:0] aluSel;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] jalrSum;
  logic [XLEN-1:0] result_d;
  logic            taken_d;
  logic [XLEN-1:0] next_pc_d;

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] imm_q;
  logic [3:0]      itype_q;
  logic [XLEN-1:0] result_q;
  logic            taken_q;
  logic [XLEN-1:0] next_pc_q;

  // Classify the instruction from its opcode; unknown opcodes are illegal.
  always_comb begin
    itype_d = ITYPE_ILL;
    case (instr[6:0])
      7'b0110011, 7'b0111011: itype_d = ITYPE_R;
      7'b0010011, 7'b0011011: itype_d = ITYPE_I;
      7'b0010111:             itype_d = ITYPE_AUIPC;
      7'b1100011:             itype_d = ITYPE_BRANCH;
      7'b0100011:             itype_d = ITYPE_STORE;
      7'b0110111:             itype_d = ITYPE_LUI;
      7'b0000011:             itype_d = ITYPE_LOAD;
      7'b1100111:             itype_d = ITYPE_JALR;
      7'b1101111:             itype_d = ITYPE_JAL;
      7'b1110011:             itype_d = ITYPE_SYS;
      default:                itype_d = ITYPE_ILL;
    endcase
  end

  // Assemble the sign-extended immediate for the instruction's format.
  always_comb begin
    imm_d = '0;
    case (itype_d)
      ITYPE_I, ITYPE_LOAD, ITYPE_JALR:
        imm_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
      ITYPE_STORE:
        imm_d = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      ITYPE_BRANCH:
        imm_d = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ITYPE_AUIPC, ITYPE_LUI:
        imm_d = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      ITYPE_JAL:
        imm_d = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
  end

  // Select ALU operands; LUI adds its immediate to zero, AUIPC/JAL use the pc.
  always_comb begin
    opA = rs1_data;
    opB = rs2_data;
    case (itype_d)
      ITYPE_AUIPC, ITYPE_JAL: opA = pc;
      ITYPE_LUI:              opA = '0;
      default:                opA = rs1_data;
    endcase
    case (itype_d)
      ITYPE_I, ITYPE_AUIPC, ITYPE_STORE, ITYPE_LUI, ITYPE_LOAD, ITYPE_JALR: opB = imm_d;
      default: opB = rs2_data;
    endcase
  end

  // Integer ALU; word ops work on the low 32 bits and sign-extend bit 31.
  always_comb begin
    isWord  = (instr[6:0] == 7'b0111011) || (instr[6:0] == 7'b0011011);
    doSub   = (itype_d == ITYPE_R) && instr[30];
    aluRes  = '0;
    wordRes = '0;
    case (instr[14:12])
      3'b000: begin
        aluRes  = doSub ? (opA - opB) : (opA + opB);
        wordRes = doSub ? (opA[31:0] - opB[31:0]) : (opA[31:0] + opB[31:0]);
      end
      3'b001: begin
        aluRes  = opA << opB[5:0];
        wordRes = opA[31:0] << opB[4:0];
      end
      3'b010: begin
        aluRes  = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
        wordRes = {31'b0, ($signed(opA[31:0]) < $signed(opB[31:0]))};
      end
      3'b011: begin
        aluRes  = {{(XLEN-1){1'b0}}, (opA < opB)};
        wordRes = {31'b0, (opA[31:0] < opB[31:0])};
      end
      3'b100: begin
        aluRes  = opA ^ opB;
        wordRes = opA[31:0] ^ opB[31:0];
      end
      3'b101: begin
        if (instr[30]) begin
          aluRes  = $signed(opA) >>> opB[5:0];
          wordRes = $signed(opA[31:0]) >>> opB[4:0];
        end else begin
          aluRes  = opA >> opB[5:0];
          wordRes = opA[31:0] >> opB[4:0];
        end
      end
      3'b110: begin
        aluRes  = opA | opB;
        wordRes = opA[31:0] | opB[31:0];
      end
      default: begin
        aluRes  = opA & opB;
        wordRes = opA[31:0] & opB[31:0];
      end
    endcase
    aluSel = isWord ? {{(XLEN-32){wordRes[31]}}, wordRes} : aluRes;
  end

  // Pick the result, evaluate the branch condition and compute the next pc.
  always_comb begin
    pcPlus4   = pc + XLEN'(4);
    jalrSum   = rs1_data + imm_d;
    result_d  = '0;
    taken_d   = 1'b0;
    next_pc_d = pcPlus4;
    case (itype_d)
      ITYPE_R, ITYPE_I:                             result_d = aluSel;
      ITYPE_AUIPC, ITYPE_LUI, ITYPE_LOAD, ITYPE_STORE: result_d = opA + opB;
      ITYPE_JAL, ITYPE_JALR:                        result_d = pcPlus4;
      default:                                      result_d = '0;
    endcase
    if (itype_d == ITYPE_BRANCH) begin
      case (instr[14:12])
        3'b000:  taken_d = (opA == opB);
        3'b001:  taken_d = (opA != opB);
        3'b100:  taken_d = ($signed(opA) < $signed(opB));
        3'b101:  taken_d = ($signed(opA) >= $signed(opB));
        3'b110:  taken_d = (opA < opB);
        3'b111:  taken_d = (opA >= opB);
        default: taken_d = 1'b0;
      endcase
    end
    if (taken_d || (itype_d == ITYPE_JAL)) begin
      next_pc_d = pc + imm_d;
    end else if (itype_d == ITYPE_JALR) begin
      next_pc_d = {jalrSum[XLEN-1:1], 1'b0};
    end
  end

  // Output register: reset clears everything, otherwise capture every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      itype_q   <= '0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      next_pc_q <= '0;
    end else begin
      valid_q   <= valid_in;
      instr_q   <= instr;
      imm_q     <= imm_d;
      itype_q   <= itype_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign valid_out    = valid_q;
  assign opcode       = instr_q[6:0];
  assign func3        = instr_q[14:12];
  assign func7        = instr_q[30];
  assign rs1          = instr_q[19:15];
  assign rs2          = instr_q[24:20];
  assign rd           = instr_q[11:7];
  assign imm          = imm_q;
  assign itype        = itype_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign next_pc      = next_pc_q;

endmodule

// File: tb/tb_ysyx_decode_alu.sv
// tb_ysyx_decode_alu: directed and randomized checks of ysyx_decode_alu
// against an instruction-level reference model.
module tb_ysyx_decode_alu;

  typedef struct packed {
    logic        validOut;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [3:0]  itype;
    logic [63:0] result;
    logic        taken;
    logic [63:0] nextPc;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        validIn;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] rs1Data;
  logic [63:0] rs2Data;
  logic        validOut;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [63:0] imm;
  logic [3:0]  itype;
  logic [63:0] result;
  logic        branchTaken;
  logic [63:0] nextPc;

  int  checks = 0;
  int  errors = 0;
  expT expv;

  ysyx_decode_alu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .valid_in(validIn), .instr(instr), .pc(pc),
    .rs1_data(rs1Data), .rs2_data(rs2Data), .valid_out(validOut),
    .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .itype(itype), .result(result),
    .branch_taken(branchTaken), .next_pc(nextPc)
  );

  always #5 clk = ~clk;

  // Instruction-level model: what an RV64I core should produce for one instruction.
  function automatic expT refModel(input logic v, input logic [31:0] ins,
                                   input logic [63:0] p, input logic [63:0] x1,
                                   input logic [63:0] x2);
    expT         e;
    longint      sx;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  cls;
    logic [31:0] ua;
    logic [31:0] ub;
    int          wa;
    int          wb;
    int          wr;
    int          sh;
    bit          isW;
    bit          f7;
    e = '0;
    e.validOut = v;
    e.opcode = ins[6:0];
    e.func3  = ins[14:12];
    e.func7  = ins[30];
    e.rs1    = ins[19:15];
    e.rs2    = ins[24:20];
    e.rd     = ins[11:7];
    f7 = ins[30];
    sx = longint'($signed(ins));
    case (ins[6:0])
      7'h33, 7'h3B: cls = 4'd0;
      7'h13, 7'h1B: cls = 4'd1;
      7'h17: cls = 4'd2;
      7'h63: cls = 4'd3;
      7'h23: cls = 4'd4;
      7'h37: cls = 4'd5;
      7'h03: cls = 4'd9;
      7'h67: cls = 4'd10;
      7'h6F: cls = 4'd11;
      7'h73: cls = 4'd14;
      default: cls = 4'd15;
    endcase
    e.itype = cls;
    case (cls)
      4'd1, 4'd9, 4'd10: e.imm = 64'(sx >>> 20);
      4'd4: e.imm = (64'(sx >>> 25) << 5) | 64'(ins[11:7]);
      4'd3: e.imm = (64'(sx >>> 31) << 12) | (64'(ins[7]) << 11) |
                    (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      4'd2, 4'd5: e.imm = 64'(sx) & ~64'hFFF;
      4'd11: e.imm = (64'(sx >>> 31) << 20) | (64'(ins[19:12]) << 12) |
                     (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      default: e.imm = 64'd0;
    endcase
    a = (cls == 4'd2 || cls == 4'd11) ? p : (cls == 4'd5) ? 64'd0 : x1;
    b = (cls == 4'd0 || cls == 4'd3 || cls == 4'd11 || cls >= 4'd14) ? x2 : e.imm;
    isW = (ins[6:0] == 7'h3B) || (ins[6:0] == 7'h1B);
    res = 64'd0;
    if (cls <= 4'd1) begin
      if (isW) begin
        ua = a[31:0]; ub = b[31:0];
        wa = int'(ua); wb = int'(ub); sh = int'(ub[4:0]);
        case (ins[14:12])
          3'd0: wr = (cls == 4'd0 && f7) ? wa - wb : wa + wb;
          3'd1: wr = wa << sh;
          3'd2: wr = (wa < wb) ? 1 : 0;
          3'd3: wr = (ua < ub) ? 1 : 0;
          3'd4: wr = wa ^ wb;
          3'd5: wr = f7 ? (wa >>> sh) : int'(ua >> sh);
          3'd6: wr = wa | wb;
          default: wr = wa & wb;
        endcase
        res = 64'(longint'(wr));
      end else begin
        sh = int'(b[5:0]);
        case (ins[14:12])
          3'd0: res = (cls == 4'd0 && f7) ? a - b : a + b;
          3'd1: res = a << sh;
          3'd2: res = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
          3'd3: res = (a < b) ? 64'd1 : 64'd0;
          3'd4: res = a ^ b;
          3'd5: res = f7 ? 64'(longint'(a) >>> sh) : a >> sh;
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
    end else if (cls == 4'd2 || cls == 4'd4 || cls == 4'd5 || cls == 4'd9) begin
      res = a + b;
    end else if (cls == 4'd10 || cls == 4'd11) begin
      res = p + 64'd4;
    end
    e.result = res;
    if (cls == 4'd3) begin
      case (ins[14:12])
        3'd0: e.taken = (x1 == x2);
        3'd1: e.taken = (x1 != x2);
        3'd4: e.taken = (longint'(x1) < longint'(x2));
        3'd5: e.taken = (longint'(x1) >= longint'(x2));
        3'd6: e.taken = (x1 < x2);
        3'd7: e.taken = (x1 >= x2);
        default: e.taken = 1'b0;
      endcase
    end
    if (e.taken || cls == 4'd11) e.nextPc = p + e.imm;
    else if (cls == 4'd10) e.nextPc = (x1 + e.imm) & ~64'd1;
    else e.nextPc = p + 64'd4;
    return e;
  endfunction

  // Single comparison point: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Compare every output against the expected record.
  task automatic checkAll(input string step, input expT e);
    checkOutput({step, ".valid_out"}, 64'(validOut), 64'(e.validOut));
    checkOutput({step, ".opcode"}, 64'(opcode), 64'(e.opcode));
    checkOutput({step, ".func3"}, 64'(func3), 64'(e.func3));
    checkOutput({step, ".func7"}, 64'(func7), 64'(e.func7));
    checkOutput({step, ".rs1"}, 64'(rs1), 64'(e.rs1));
    checkOutput({step, ".rs2"}, 64'(rs2), 64'(e.rs2));
    checkOutput({step, ".rd"}, 64'(rd), 64'(e.rd));
    checkOutput({step, ".imm"}, imm, e.imm);
    checkOutput({step, ".itype"}, 64'(itype), 64'(e.itype));
    checkOutput({step, ".result"}, result, e.result);
    checkOutput({step, ".branch_taken"}, 64'(branchTaken), 64'(e.taken));
    checkOutput({step, ".next_pc"}, nextPc, e.nextPc);
  endtask

  // Drive one instruction, let the edge capture it, and land 1 time unit after.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] p,
                               input logic [63:0] x1, input logic [63:0] x2);
    rst = 1'b0; validIn = v; instr = ins; pc = p; rs1Data = x1; rs2Data = x2;
    expv = refModel(v, ins, p, x1, x2);
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  opList [12] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h17, 7'h63,
                               7'h23, 7'h37, 7'h03, 7'h67, 7'h6F, 7'h73};
  logic [31:0] rnd;
  logic [6:0]  op;
  logic [63:0] r1;
  logic [63:0] r2;
  logic [63:0] rpc;
  int          idx;

  initial begin
    rst = 1'b1; validIn = 1'b1; instr = 32'h00500093; pc = 64'h1000;
    rs1Data = 64'd9; rs2Data = 64'd9;
    @(posedge clk); @(posedge clk); #1;
    checkAll("reset", '0);

    applyStimulus(1'b1, 32'h00500093, 64'h1000, 64'd0, 64'd0);
    checkAll("addi", expv);
    checkOutput("addi.itype_const", 64'(itype), 64'h1);
    checkOutput("addi.rd_const", 64'(rd), 64'd1);
    checkOutput("addi.imm_const", imm, 64'd5);
    checkOutput("addi.result_const", result, 64'd5);
    checkOutput("addi.next_pc_const", nextPc, 64'h1004);

    applyStimulus(1'b1, 32'h40208033, 64'h2000, 64'd3, 64'd5);
    checkAll("sub", expv);
    checkOutput("sub.result_const", result, 64'hFFFFFFFFFFFFFFFE);
    checkOutput("sub.func7_const", 64'(func7), 64'd1);

    applyStimulus(1'b1, 32'h0010809B, 64'h2004, 64'h7FFFFFFF, 64'd0);
    checkAll("addiw", expv);
    checkOutput("addiw.result_const", result, 64'hFFFFFFFF80000000);

    applyStimulus(1'b1, 32'h00208463, 64'h80000000, 64'd7, 64'd7);
    checkAll("beq_taken", expv);
    checkOutput("beq_taken.taken_const", 64'(branchTaken), 64'd1);
    checkOutput("beq_taken.next_pc_const", nextPc, 64'h80000008);

    applyStimulus(1'b1, 32'h00208463, 64'h80000000, 64'd7, 64'd8);
    checkAll("beq_not", expv);
    checkOutput("beq_not.taken_const", 64'(branchTaken), 64'd0);
    checkOutput("beq_not.next_pc_const", nextPc, 64'h80000004);

    applyStimulus(1'b1, 32'hFFC12083, 64'h3000, 64'h100, 64'd0);
    checkAll("lw", expv);
    checkOutput("lw.itype_const", 64'(itype), 64'h9);
    checkOutput("lw.imm_const", imm, 64'hFFFFFFFFFFFFFFFC);
    checkOutput("lw.result_const", result, 64'hFC);

    applyStimulus(1'b1, 32'h00001297, 64'h80000000, 64'd0, 64'd0);
    checkAll("auipc", expv);
    checkOutput("auipc.result_const", result, 64'h80001000);

    applyStimulus(1'b0, 32'h00500093, 64'h4000, 64'd0, 64'd0);
    checkAll("invalid_still_updates", expv);

    rst = 1'b1; validIn = 1'b1; instr = 32'h00500093; pc = 64'h5000;
    rs1Data = 64'd1; rs2Data = 64'd2;
    @(posedge clk); #1;
    checkAll("reset_over_valid", '0);
    applyStimulus(1'b1, 32'h00500093, 64'h5000, 64'd0, 64'd0);
    checkAll("after_reset", expv);
    checkOutput("after_reset.valid_const", 64'(validOut), 64'd1);

    for (int i = 0; i < 400; i++) begin
      idx = $urandom_range(0, 12);
      rnd = $urandom;
      op  = (idx == 12) ? rnd[6:0] : opList[idx];
      rnd = $urandom;
      r1  = {$urandom, $urandom};
      r2  = {$urandom, $urandom};
      rpc = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: r2 = r1;
        1: begin r1 = 64'h8000000000000000; r2 = 64'h7FFFFFFFFFFFFFFF; end
        2: begin r1 = 64'(rnd[9:0]); r2 = 64'(rnd[19:10]); end
        default: ;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), {rnd[31:7], op}, rpc, r1, r2);
      checkAll("random", expv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
